hit_resolver: RTL and testbench
===============================

Name: hit_resolver

Overview:
- Frame-synchronous successor to the combinational collision check.
- Compares N_HITBOX attacker hitboxes against one target hurtbox, with lowest-index priority.
- Registers at most one contact per attack instance and classifies it as hit or block.
- Runs a hitstun/blockstun frame counter for the target. Sits between the attacker's move FSM and the target's state machine; one instance per attacker→target direction.

Parameters:
COORD_W, 10, coordinate width in bits
N_HITBOX, 2, number of attacker hitboxes (1..8)
STUN_W, 6, stun counter width
HIT_STUN, 20, frames of stun loaded on a hit (< 2^STUN_W)
BLOCK_STUN, 12, frames of stun loaded on a block (< 2^STUN_W)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
frame_tick  in  1  one-cycle pulse per game frame; sampling strobe
attack_flag  in  1  attacker is in an attacking move
attack_start  in  1  one-cycle pulse: new attack instance (re-arms multi-hit moves)
hb_x1, hb_x2, hb_y1, hb_y2  in  N_HITBOX*COORD_W each  packed hitbox edges; box i at bits [i*COORD_W +: COORD_W]
hb_active  in  N_HITBOX  per-hitbox enable
hu_x1, hu_x2, hu_y1, hu_y2  in  COORD_W each  target hurtbox edges
hu_active  in  1  target hurtbox enable
target_is_blocking  in  1  target holding block
got_hit_target  out  1  one-cycle pulse: hit registered
got_blocked_target  out  1  one-cycle pulse: block registered
hit_index  out  3  index of the contacting hitbox; held until the next contact
stun_active  out  1  stun_count != 0
stun_is_block  out  1  current stun came from a block
stun_count  out  STUN_W  remaining stun frames

Behaviour:
- Reset: all outputs 0; FSM state IDLE.
- overlap[i] = hb_active[i] & hu_active & (hb_x1[i] < hu_x2) & (hb_x2[i] > hu_x1) & (hb_y1[i] < hu_y2) & (hb_y2[i] > hu_y1). All comparisons are unsigned and strict; touching edges do not overlap.
- contact = attack_flag & |overlap. sel = lowest i with overlap[i]=1.
- FSM states: IDLE, ARMED, SPENT.
  - IDLE -> ARMED when attack_flag=1 (any cycle).
  - ARMED -> SPENT on a cycle with frame_tick & contact; that contact is registered.
  - ARMED -> IDLE when attack_flag=0.
  - SPENT -> ARMED on attack_start=1 with attack_flag=1. No contact is registered in that cycle, even if frame_tick & contact.
  - SPENT -> IDLE when attack_flag=0.
  - attack_flag=0 overrides all other transitions (-> IDLE).
- Registered contact sets the outputs one cycle after the sampling cycle:
  - got_hit_target = !target_is_blocking.
  - got_blocked_target = target_is_blocking.
  - hit_index = sel.
  - stun_count loads HIT_STUN or BLOCK_STUN; stun_is_block is set accordingly.
- got_hit_target and got_blocked_target are never high together. Each pulses for exactly one clk.
- target_is_blocking is sampled in the same cycle as the overlap.
- Stun counter decrements by 1 on frame_tick when nonzero and no load occurs. Load wins over decrement.
- A contact during active stun reloads the counter (combo/re-block). stun_is_block is updated on reload.
- Counter holds at 0 and never wraps. stun_is_block clears when the count reaches 0.
- If HIT_STUN=0 or BLOCK_STUN=0, the pulse still fires and stun_active stays 0.
- Contacts are sampled only on frame_tick; overlaps between ticks are ignored.
- rst asserted mid-stun or in SPENT: next cycle all outputs are 0 and the state is IDLE. No pulse is emitted in the reset cycle.

Test Plan:
- Box0 (100..140, 50..90) vs hurtbox (130..170, 40..100), attack_flag=1, not blocking, frame_tick → got_hit_target pulse one cycle later, hit_index=0, stun_count=20, then decrements to 0 after 20 ticks with stun_active dropping on the same cycle.
- Same geometry held for 5 frames → exactly one pulse. Then attack_start pulse → next tick gives a second pulse and stun_count reloads to 20.
- Boxes 0 and 1 both overlapping, target_is_blocking=1 → got_blocked_target only, hit_index=0, stun_is_block=1, stun_count=12. With box0 disabled → hit_index=1.
- Edge touch (hb_x2=130, hu_x1=130) or hu_active=0 or attack_flag=0 → no pulse, stun_count unchanged.
- Overlap present but no frame_tick for 10 cycles → no pulse. The first tick produces the pulse.
- rst during stun_count=7 in SPENT → all outputs 0 next cycle. With geometry unchanged and attack_flag=1, a new hit is registered on the next tick.

Source files
------------

// File: rtl/hit_resolver.sv
// Frame-synchronous hitbox/hurtbox resolver. Registers at most one contact per attack
// instance, classifies it as a hit or a block, and runs the target's stun counter.
//
// state | meaning
// IDLE  | attacker not attacking
// ARMED | attack in progress, contact not yet landed
// SPENT | this attack instance already landed; waits for attack_start to re-arm
module hit_resolver #(
    parameter int COORD_W    = 10,
    parameter int N_HITBOX   = 2,
    parameter int STUN_W     = 6,
    parameter int HIT_STUN   = 20,
    parameter int BLOCK_STUN = 12
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_tick,
    input  logic                          attack_flag,
    input  logic                          attack_start,
    input  logic [N_HITBOX*COORD_W-1:0]   hb_x1,
    input  logic [N_HITBOX*COORD_W-1:0]   hb_x2,
    input  logic [N_HITBOX*COORD_W-1:0]   hb_y1,
    input  logic [N_HITBOX*COORD_W-1:0]   hb_y2,
    input  logic [N_HITBOX-1:0]           hb_active,
    input  logic [COORD_W-1:0]            hu_x1,
    input  logic [COORD_W-1:0]            hu_x2,
    input  logic [COORD_W-1:0]            hu_y1,
    input  logic [COORD_W-1:0]            hu_y2,
    input  logic                          hu_active,
    input  logic                          target_is_blocking,
    output logic                          got_hit_target,
    output logic                          got_blocked_target,
    output logic [2:0]                    hit_index,
    output logic                          stun_active,
    output logic                          stun_is_block,
    output logic [STUN_W-1:0]             stun_count
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ARMED = 2'd1;
    localparam logic [1:0] SPENT = 2'd2;

    localparam logic [STUN_W-1:0] HIT_LOAD   = STUN_W'(HIT_STUN);
    localparam logic [STUN_W-1:0] BLOCK_LOAD = STUN_W'(BLOCK_STUN);

    logic [1:0]          state;
    logic [1:0]          state_nxt;
    logic [N_HITBOX-1:0] overlap;
    logic [2:0]          sel;
    logic                contact;
    logic                register_contact;

    // Strict compares: boxes that only share an edge do not collide.
    always_comb begin
        overlap = '0;
        for (int i = 0; i < N_HITBOX; i++) begin
            overlap[i] = hb_active[i] & hu_active
                       & (hb_x1[i*COORD_W +: COORD_W] < hu_x2)
                       & (hb_x2[i*COORD_W +: COORD_W] > hu_x1)
                       & (hb_y1[i*COORD_W +: COORD_W] < hu_y2)
                       & (hb_y2[i*COORD_W +: COORD_W] > hu_y1);
        end
    end

    // Scanning downward leaves the lowest overlapping index in sel.
    always_comb begin
        sel = '0;
        for (int i = N_HITBOX - 1; i >= 0; i--) begin
            if (overlap[i]) begin
                sel = 3'(i);
            end
        end
    end

    assign contact          = attack_flag & (|overlap);
    assign register_contact = (state == ARMED) & frame_tick & contact;

    always_comb begin
        state_nxt = state;
        if (!attack_flag) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    state_nxt = ARMED;
                ARMED:   if (register_contact) state_nxt = SPENT;
                SPENT:   if (attack_start) state_nxt = ARMED;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= IDLE;
            got_hit_target     <= 1'b0;
            got_blocked_target <= 1'b0;
            hit_index          <= '0;
            stun_is_block      <= 1'b0;
            stun_count         <= '0;
        end else begin
            state              <= state_nxt;
            got_hit_target     <= 1'b0;
            got_blocked_target <= 1'b0;
            if (register_contact) begin
                got_hit_target     <= ~target_is_blocking;
                got_blocked_target <= target_is_blocking;
                hit_index          <= sel;
                if (target_is_blocking) begin
                    stun_count    <= BLOCK_LOAD;
                    stun_is_block <= (BLOCK_LOAD != '0);
                end else begin
                    stun_count    <= HIT_LOAD;
                    stun_is_block <= 1'b0;
                end
            end else if (frame_tick && (stun_count != '0)) begin
                stun_count <= stun_count - 1'b1;
                if (stun_count == STUN_W'(1)) begin
                    stun_is_block <= 1'b0;
                end
            end
        end
    end

    assign stun_active = (stun_count != '0);

endmodule

// File: tb/tb_hit_resolver.sv
// Bench for hit_resolver: directed scenarios followed by randomized frames, all
// checked against a behavioural model of attack instances and stun frames.
module tb_hit_resolver;

    localparam int W  = 10;
    localparam int N  = 2;
    localparam int SW = 6;
    localparam int HS = 20;
    localparam int BS = 12;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              frame_tick = 1'b0;
    logic              attack_flag = 1'b0;
    logic              attack_start = 1'b0;
    logic [N*W-1:0]    hb_x1, hb_x2, hb_y1, hb_y2;
    logic [N-1:0]      hb_active = '0;
    logic [W-1:0]      hu_x1 = '0, hu_x2 = '0, hu_y1 = '0, hu_y2 = '0;
    logic              hu_active = 1'b0;
    logic              target_is_blocking = 1'b0;
    logic              got_hit_target, got_blocked_target, stun_active, stun_is_block;
    logic [2:0]        hit_index;
    logic [SW-1:0]     stun_count;

    logic [W-1:0] bx1 [N];
    logic [W-1:0] bx2 [N];
    logic [W-1:0] by1 [N];
    logic [W-1:0] by2 [N];

    for (genvar g = 0; g < N; g++) begin : g_pack
        assign hb_x1[g*W +: W] = bx1[g];
        assign hb_x2[g*W +: W] = bx2[g];
        assign hb_y1[g*W +: W] = by1[g];
        assign hb_y2[g*W +: W] = by2[g];
    end

    hit_resolver #(.COORD_W(W), .N_HITBOX(N), .STUN_W(SW), .HIT_STUN(HS), .BLOCK_STUN(BS)) dut (
        .clk(clk), .rst(rst), .frame_tick(frame_tick), .attack_flag(attack_flag),
        .attack_start(attack_start), .hb_x1(hb_x1), .hb_x2(hb_x2), .hb_y1(hb_y1),
        .hb_y2(hb_y2), .hb_active(hb_active), .hu_x1(hu_x1), .hu_x2(hu_x2),
        .hu_y1(hu_y1), .hu_y2(hu_y2), .hu_active(hu_active),
        .target_is_blocking(target_is_blocking), .got_hit_target(got_hit_target),
        .got_blocked_target(got_blocked_target), .hit_index(hit_index),
        .stun_active(stun_active), .stun_is_block(stun_is_block), .stun_count(stun_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Model: whether an attack is underway, whether this instance already landed,
    // and the expected output values.
    bit attacking = 0;
    bit landed    = 0;
    int m_hit = 0, m_blk = 0, m_idx = 0, m_cnt = 0, m_isblk = 0;
    int pulses = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int first_overlap();
        for (int i = 0; i < N; i++) begin
            if (hb_active[i] && hu_active &&
                int'(bx1[i]) < int'(hu_x2) && int'(bx2[i]) > int'(hu_x1) &&
                int'(by1[i]) < int'(hu_y2) && int'(by2[i]) > int'(hu_y1))
                return i;
        end
        return -1;
    endfunction

    task automatic model_update();
        int  who;
        bit  lands;
        who = first_overlap();
        m_hit = 0;
        m_blk = 0;
        if (rst) begin
            attacking = 0; landed = 0;
            m_idx = 0; m_cnt = 0; m_isblk = 0;
            return;
        end
        lands = attacking && !landed && attack_flag && frame_tick && (who >= 0);
        if (!attack_flag) begin
            attacking = 0; landed = 0;
        end else if (!attacking) begin
            attacking = 1; landed = 0;
        end else if (landed) begin
            if (attack_start) landed = 0;
        end else if (lands) begin
            landed = 1;
        end
        if (lands) begin
            m_idx = who;
            if (target_is_blocking) begin
                m_blk = 1; m_cnt = BS; m_isblk = (BS > 0);
            end else begin
                m_hit = 1; m_cnt = HS; m_isblk = 0;
            end
        end else if (frame_tick && m_cnt > 0) begin
            m_cnt = m_cnt - 1;
            if (m_cnt == 0) m_isblk = 0;
        end
    endtask

    task automatic step();
        model_update();
        @(posedge clk);
        #1;
        if (got_hit_target || got_blocked_target) pulses++;
        check("got_hit", int'(got_hit_target), m_hit);
        check("got_blocked", int'(got_blocked_target), m_blk);
        check("hit_index", int'(hit_index), m_idx);
        check("stun_count", int'(stun_count), m_cnt);
        check("stun_active", int'(stun_active), int'(m_cnt > 0));
        check("stun_is_block", int'(stun_is_block), m_isblk);
    endtask

    task automatic tick_step();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic start_step();
        attack_start = 1'b1;
        step();
        attack_start = 1'b0;
    endtask

    task automatic set_box(input int i, input int x1, input int x2, input int y1, input int y2);
        bx1[i] = W'(x1); bx2[i] = W'(x2); by1[i] = W'(y1); by2[i] = W'(y2);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_box(i, 0, 0, 0, 0);
        rst = 1'b1;
        step();
        step();
        check("reset_stun", int'(stun_count), 0);
        check("reset_hit", int'(got_hit_target), 0);
        rst = 1'b0;

        // Basic hit on box 0
        set_box(0, 100, 140, 50, 90);
        set_box(1, 0, 0, 0, 0);
        hb_active = 2'b01;
        hu_x1 = 130; hu_x2 = 170; hu_y1 = 40; hu_y2 = 100; hu_active = 1'b1;
        attack_flag = 1'b1;
        step();
        pulses = 0;
        tick_step();
        check("first_hit_pulse", int'(got_hit_target), 1);
        check("first_hit_stun", int'(stun_count), 20);
        check("first_hit_idx", int'(hit_index), 0);
        step();
        check("pulse_one_cycle", int'(got_hit_target), 0);
        for (int k = 0; k < 19; k++) begin
            tick_step();
            step();
        end
        check("stun_one_left", int'(stun_count), 1);
        tick_step();
        check("stun_expired", int'(stun_count), 0);
        check("stun_active_drop", int'(stun_active), 0);
        check("single_pulse_held", pulses, 1);

        // Re-arm via attack_start
        start_step();
        tick_step();
        check("rearm_hit", int'(got_hit_target), 1);
        check("rearm_stun", int'(stun_count), 20);

        // Both boxes overlap while blocking: lowest index wins
        set_box(1, 120, 160, 60, 80);
        hb_active = 2'b11;
        target_is_blocking = 1'b1;
        start_step();
        tick_step();
        check("block_pulse", int'(got_blocked_target), 1);
        check("block_no_hit", int'(got_hit_target), 0);
        check("block_idx", int'(hit_index), 0);
        check("block_stun", int'(stun_count), 12);
        check("block_flag", int'(stun_is_block), 1);
        hb_active = 2'b10;
        start_step();
        tick_step();
        check("box1_idx", int'(hit_index), 1);
        target_is_blocking = 1'b0;

        // Non-overlap cases: touching edge, hurtbox off, not attacking
        hb_active = 2'b01;
        set_box(0, 100, 130, 50, 90);
        pulses = 0;
        start_step();
        tick_step();
        tick_step();
        set_box(0, 100, 140, 50, 90);
        hu_active = 1'b0;
        tick_step();
        hu_active = 1'b1;
        attack_flag = 1'b0;
        tick_step();
        tick_step();
        check("no_contact_pulses", pulses, 0);

        // Overlap without frame ticks
        attack_flag = 1'b1;
        for (int k = 0; k < 10; k++) step();
        check("no_tick_pulses", pulses, 0);
        tick_step();
        check("first_tick_hit", int'(got_hit_target), 1);

        // Reset mid-stun while spent
        for (int k = 0; k < 13; k++) tick_step();
        check("stun_at_7", int'(stun_count), 7);
        rst = 1'b1;
        tick_step();
        rst = 1'b0;
        check("rst_stun", int'(stun_count), 0);
        check("rst_idx", int'(hit_index), 0);
        step();
        tick_step();
        check("post_rst_hit", int'(got_hit_target), 1);

        // Randomized frames
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 15) == 0) attack_flag = ~attack_flag;
            attack_start       = ($urandom_range(0, 7) == 0);
            frame_tick         = ($urandom_range(0, 2) == 0);
            target_is_blocking = $urandom_range(0, 1) == 1;
            rst                = ($urandom_range(0, 199) == 0);
            hb_active          = N'($urandom);
            hu_active          = ($urandom_range(0, 7) != 0);
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < N; i++)
                    set_box(i, $urandom_range(0, 40), $urandom_range(20, 63),
                            $urandom_range(0, 40), $urandom_range(20, 63));
                hu_x1 = W'($urandom_range(0, 40)); hu_x2 = W'($urandom_range(20, 63));
                hu_y1 = W'($urandom_range(0, 40)); hu_y2 = W'($urandom_range(20, 63));
            end
            step();
        end
        rst = 1'b0;
        frame_tick = 1'b0;
        attack_start = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
